mem_io_bridge: RTL
==================

MEM_IO_BRIDGE -- requirements
Module: mem_io_bridge

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): WORD_W, 9, bus word width; RAM_DEPTH, 128, data RAM words; FIFO_DEPTH, 8, output FIFO entries (power of two).
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, the single clock; all state is on its rising edge.
- resetn, in, 1, asynchronous, active-low reset.
- ADDR, in, WORD_W, processor address.
- Dout, in, WORD_W, processor write data.
- W, in, 1, processor write strobe.
- Din, out, WORD_W, read data returned to the processor.
- SW, in, WORD_W, asynchronous switch inputs.
- LEDR, out, WORD_W, LED register.
- out_data, out, WORD_W, FIFO head word.
- out_valid, out, 1, FIFO non-empty.
- out_ready, in, 1, consumer accepts the head word.

Function
REQ-003 The address map SHALL decode ADDR[8:7] as follows:
- 00: RAM, word index ADDR[6:0].
- 01: LED register.
- 10: FIFO push on write; FIFO status on read.
- 11: switches (read-only; writes ignored).
REQ-004 A write SHALL occur on a rising clk edge with W=1 to the region selected by ADDR in that cycle.
REQ-005 Din SHALL be registered: the data for the ADDR presented in cycle N SHALL appear on Din in cycle N+1, for every region.
REQ-006 A RAM read-during-write to the same address SHALL return the old data.
REQ-007 SW SHALL pass through a two-flop synchronizer before it is readable. A switch change SHALL be visible on Din no earlier than 3 cycles after it occurs.
REQ-008 The FIFO status word SHALL be laid out as:
- [8] overflow (sticky).
- [7] full.
- [6] empty.
- [5:4] zero.
- [3:0] count (0..8).
REQ-009 A FIFO push SHALL be accepted when not full, or when full and out_ready=1 with out_valid=1 in the same cycle (simultaneous pop).
REQ-010 A push to a full FIFO with no simultaneous pop SHALL be dropped. The FIFO contents SHALL be unchanged and overflow SHALL be set.
REQ-011 A status read SHALL clear overflow on the edge that registers the status into Din. If a new overflow event occurs in that same cycle, overflow SHALL remain 1.
REQ-012 The FIFO SHALL have no fall-through: a push into an empty FIFO SHALL raise out_valid in the next cycle.
- A pop (out_valid and out_ready) SHALL advance the head in the next cycle.
- out_ready while empty SHALL have no effect.
REQ-013 The FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH. count SHALL be the pointer difference, with full at count=FIFO_DEPTH.
REQ-014 out_data and out_valid SHALL depend only on registered state.

Reset
REQ-015 While resetn=0, these SHALL be held:
- Din=0, LEDR=0, out_valid=0, out_data=0.
- FIFO pointers and count = 0, overflow=0.
- Synchronizer flops = 0.
REQ-016 RAM contents SHALL NOT be reset.
REQ-017 Assertion of resetn mid-operation SHALL discard all FIFO contents immediately. A push coincident with reset assertion SHALL be lost.

Configuration
REQ-018 Macro LED_REG_EN defined: the LED register SHALL be present; writes set LEDR and reads return LEDR.
REQ-019 Macro LED_REG_EN undefined: LEDR SHALL be constant 0, region-01 writes SHALL be ignored, and region-01 reads SHALL return 0.

Structure
REQ-020 A shared package proc_pkg SHALL hold:
- WORD_W.
- The region encodings (REGION_RAM, REGION_LED, REGION_FIFO, REGION_SW).
- The status-bit index constants.
REQ-021 The FIFO SHALL be a sub-module io_fifo (push/pop, data, count, full, empty, overflow, status-clear). Decode, RAM, LED, synchronizer and Din mux SHALL live in mem_io_bridge.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- RAM: write 0x1A5 to address 0x005, read 0x005 next cycle -> Din=0x1A5 one cycle after the read address.
- LED: write 0x0F0 to 0x080 -> LEDR=0x0F0. Repeat with LED_REG_EN undefined -> LEDR=0 and a read of 0x080 returns 0.
- FIFO fill: push 1..9 with out_ready=0 -> 9th push dropped, status=0x188 (overflow=1, full=1, count=8). Status reread -> 0x088.
- FIFO drain: from 8 entries, hold out_ready=1 -> out_data 1..8 in order, one per cycle, then out_valid=0, status=0x040.
- Full simultaneous: with FIFO full, push 0x055 while popping -> count stays 8, overflow stays 0, 0x055 emerges last.
- Switches and reset: set SW=0x123 and read 0x180 -> Din=0x123 by the 3rd cycle. Assert resetn=0 with FIFO non-empty -> out_valid=0 and Din=0 immediately.

Source files
------------

// File: rtl/proc_pkg.sv
// proc_pkg: constants shared by mem_io_bridge and io_fifo.
// Holds the bus word width, the ADDR[8:7] region encodings, the FIFO status
// word bit positions and a helper that assembles the status word.
package proc_pkg;

    // Default bus word width.
    localparam int WORD_W = 9;

    // Address regions selected by the top two address bits.
    typedef enum logic [1:0] {
        REGION_RAM  = 2'b00,
        REGION_LED  = 2'b01,
        REGION_FIFO = 2'b10,
        REGION_SW   = 2'b11
    } region_e;

    // FIFO status word layout; bits [5:4] always read as zero.
    localparam int ST_OVF     = 8;
    localparam int ST_FULL    = 7;
    localparam int ST_EMPTY   = 6;
    localparam int ST_CNT_MSB = 3;
    localparam int ST_CNT_LSB = 0;
    localparam int ST_CNT_W   = ST_CNT_MSB - ST_CNT_LSB + 1;

    // Build the status word returned by a read of the FIFO region.
    function automatic logic [WORD_W-1:0] pack_status(
        input logic                ovf,
        input logic                full,
        input logic                empty,
        input logic [ST_CNT_W-1:0] count
    );
        logic [WORD_W-1:0] s;
        s                          = '0;
        s[ST_OVF]                  = ovf;
        s[ST_FULL]                 = full;
        s[ST_EMPTY]                = empty;
        s[ST_CNT_MSB:ST_CNT_LSB]   = count;
        return s;
    endfunction

endpackage

// File: rtl/io_fifo.sv
// io_fifo: output FIFO of mem_io_bridge.
// Registered-output FIFO without fall-through: a pushed word becomes visible
// on the cycle after the push. Pointers carry one extra wrap bit so that the
// pointer difference is the occupancy (0..DEPTH). A push while full is only
// accepted if the head is popped on the same edge; otherwise it is dropped
// and the sticky overflow flag is set. clr_ovf_i clears overflow unless a new
// overflow occurs on the same edge.
module io_fifo #(
    parameter int  DATA_W = proc_pkg::WORD_W,
    parameter int  DEPTH  = 8,
    localparam int AW     = $clog2(DEPTH),
    localparam int CW     = AW + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_ready_i,
    input  logic              clr_ovf_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    output logic [CW-1:0]     count_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              ovf_o
);

    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic              ovf_q, ovf_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [CW-1:0]     count;
    logic              empty;
    logic              full;
    logic              do_pop;
    logic              do_push;
    logic              ovf_event;

    // Occupancy and handshake qualification from registered pointers.
    assign count     = wr_ptr_q - rd_ptr_q;
    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign do_pop    = pop_ready_i && !empty;
    assign do_push   = push_i && (!full || do_pop);
    assign ovf_event = push_i && full && !do_pop;

    // Next-state for pointers and the sticky overflow flag.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (clr_ovf_i) begin
            ovf_d = 1'b0;
        end
        if (ovf_event) begin
            ovf_d = 1'b1;
        end
    end

    // Control state: pointers and overflow, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage array, written on an accepted push.
    // NOTE: storage is deliberately not reset; emptiness comes from the pointers, and data_o is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
        end
    end

    // Outputs are functions of registered state only.
    assign data_o  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign valid_o = !empty;
    assign count_o = count;
    assign full_o  = full;
    assign empty_o = empty;
    assign ovf_o   = ovf_q;

endmodule

// File: rtl/mem_io_bridge.sv
// mem_io_bridge: processor memory/IO bridge.
// ADDR[8:7] selects RAM, LED register, output FIFO (push on write, status on
// read) or synchronised switches. Din is registered: the data for the address
// presented in cycle N appears in cycle N+1. RAM read-during-write returns the
// old word. Optional LED register: define LED_REG_EN to build it; without it
// LEDR is tied to 0, LED writes are ignored and LED reads return 0.
module mem_io_bridge #(
    parameter int WORD_W     = proc_pkg::WORD_W,
    parameter int RAM_DEPTH  = 128,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [WORD_W-1:0] ADDR,
    input  logic [WORD_W-1:0] Dout,
    input  logic              W,
    output logic [WORD_W-1:0] Din,
    input  logic [WORD_W-1:0] SW,
    output logic [WORD_W-1:0] LEDR,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
);
    import proc_pkg::*;

    localparam int RAM_AW  = $clog2(RAM_DEPTH);
    localparam int FIFO_CW = $clog2(FIFO_DEPTH) + 1;

    // Address decode.
    region_e           region;
    logic [RAM_AW-1:0] ram_idx;
    logic              wr_ram;
    logic              fifo_push;
    logic              status_rd;

    assign region    = region_e'(ADDR[WORD_W-1 -: 2]);
    assign ram_idx   = ADDR[RAM_AW-1:0];
    assign wr_ram    = W && (region == REGION_RAM);
    assign fifo_push = W && (region == REGION_FIFO);
    // Any non-write cycle addressing the FIFO region is a status read.
    assign status_rd = !W && (region == REGION_FIFO);

    // Data RAM with asynchronous read; Din is the only register on the read path.
    logic [WORD_W-1:0] ram_q [RAM_DEPTH];

    // RAM write port; the read below sees the pre-edge contents, giving old-data read-during-write.
    always_ff @(posedge clk) begin
        if (wr_ram) begin
            ram_q[ram_idx] <= Dout;
        end
    end

`ifdef LED_REG_EN
    logic              wr_led;
    logic [WORD_W-1:0] led_q;

    assign wr_led = W && (region == REGION_LED);

    // LED register, loaded by a write to the LED region.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            led_q <= '0;
        end else if (wr_led) begin
            led_q <= Dout;
        end
    end

    assign LEDR = led_q;
`else
    assign LEDR = '0;
`endif

    // Two-flop synchroniser for the asynchronous switch inputs.
    logic [WORD_W-1:0] sw_meta_q;
    logic [WORD_W-1:0] sw_sync_q;

    // Switch synchroniser chain.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            sw_meta_q <= SW;
            sw_sync_q <= sw_meta_q;
        end
    end

    // Output FIFO.
    logic [FIFO_CW-1:0] fifo_count;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_ovf;
    logic [WORD_W-1:0]  fifo_status;

    io_fifo #(
        .DATA_W (WORD_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (resetn),
        .push_i      (fifo_push),
        .push_data_i (Dout),
        .pop_ready_i (out_ready),
        .clr_ovf_i   (status_rd),
        .data_o      (out_data),
        .valid_o     (out_valid),
        .count_o     (fifo_count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .ovf_o       (fifo_ovf)
    );

    assign fifo_status = WORD_W'(pack_status(fifo_ovf, fifo_full, fifo_empty,
                                             ST_CNT_W'(fifo_count)));

    // Read-data mux for the region addressed this cycle.
    logic [WORD_W-1:0] din_d;
    logic [WORD_W-1:0] din_q;

    always_comb begin
        din_d = '0;
        unique case (region)
            REGION_RAM:  din_d = ram_q[ram_idx];
`ifdef LED_REG_EN
            REGION_LED:  din_d = led_q;
`else
            REGION_LED:  din_d = '0;
`endif
            REGION_FIFO: din_d = fifo_status;
            REGION_SW:   din_d = sw_sync_q;
        endcase
    end

    // Registered read data returned to the processor.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            din_q <= '0;
        end else begin
            din_q <= din_d;
        end
    end

    assign Din = din_q;

endmodule
